// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- memory BIST sequencer.
//   state_t    : sequencer FSM states (IDLE, RUN, DRAIN, DONE)
//   march_op_t : per-cycle memory operation (W0, W1, R0, R1)
//   elem_t     : one march element (op count, direction, op list)
//   elem_info  : element table lookup for March C-:
//                M0 up(w0) M1 up(r0,w1) M2 up(r1,w0)
//                M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
package mbist_pkg;

  localparam int unsigned NUM_ELEM  = 6;
  localparam logic [2:0]  LAST_ELEM = 3'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    W0,
    W1,
    R0,
    R1
  } march_op_t;

  typedef struct packed {
    logic      two_ops;  // element applies two ops per address
    logic      down;     // address order N-1..0
    march_op_t op0;
    march_op_t op1;
  } elem_t;

  function automatic elem_t elem_info(input logic [2:0] idx);
    elem_t e;
    e = '{two_ops: 1'b0, down: 1'b0, op0: W0, op1: W0};
    case (idx)
      3'd0: e = '{two_ops: 1'b0, down: 1'b0, op0: W0, op1: W0};
      3'd1: e = '{two_ops: 1'b1, down: 1'b0, op0: R0, op1: W1};
      3'd2: e = '{two_ops: 1'b1, down: 1'b0, op0: R1, op1: W0};
      3'd3: e = '{two_ops: 1'b1, down: 1'b1, op0: R0, op1: W1};
      3'd4: e = '{two_ops: 1'b1, down: 1'b1, op0: R1, op1: W0};
      3'd5: e = '{two_ops: 1'b0, down: 1'b0, op0: R0, op1: W0};
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the march sequencer.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears to 0)
//   load_i         : load start address (0, or N-1 when load_down_i)
//   load_down_i    : direction of the element being loaded
//   step_i         : advance one address in direction dir_down_i
//   dir_down_i     : direction of the element currently running
//   addr_o         : current address
//   tc_o           : terminal count (last address for dir_down_i)
module mbist_addr_gen #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              dir_down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tc_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = dir_down_i ? (addr_q - 1'b1) : (addr_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = dir_down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_sequencer.sv
// March C- memory BIST sequencer: one memory op per RUN cycle, read data
// compared one cycle after each read, sticky fail flag.
//   clk, rst   : clock, synchronous active-high reset
//   start      : launch level, sampled only in IDLE
//   addr, wr_en, rd_en, wdata : memory op for the current cycle
//   rdata      : memory read data, valid one cycle after rd_en
//   busy, done : RUN/DRAIN indicator, single-cycle completion pulse
//   fail, fail_addr, fail_elem : sticky mismatch flag and first-fail info
// Build option: MBIST_FAIL_CAPTURE_EN enables fail_addr/fail_elem capture;
// when undefined both outputs are tied to 0.
module mbist_march_sequencer
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  state_t      state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic        opsel_q, opsel_d;
  logic        pend_q, pend_d;
  logic        exp_one_q, exp_one_d;
  logic        fail_q, fail_d;

  elem_t       cur;
  march_op_t   op;
  logic        launch;
  logic        mismatch;

  logic              ag_load;
  logic              ag_load_down;
  logic              ag_step;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_tc;

  mbist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ag_load),
    .load_down_i(ag_load_down),
    .step_i     (ag_step),
    .dir_down_i (cur.down),
    .addr_o     (ag_addr),
    .tc_o       (ag_tc)
  );

  // Sequencing: the address counter is preloaded for element 0 on launch
  // and for element e+1 on the last op of element e, so RUN never idles.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    opsel_d      = opsel_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    launch       = 1'b0;
    cur          = elem_info(elem_q);
    op           = opsel_q ? cur.op1 : cur.op0;
    addr         = '0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    wdata        = '0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          elem_d       = '0;
          opsel_d      = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = elem_info('0).down;
          launch       = 1'b1;
        end
      end
      RUN: begin
        busy  = 1'b1;
        addr  = ag_addr;
        wr_en = (op == W0) || (op == W1);
        rd_en = (op == R0) || (op == R1);
        wdata = (op == W1) ? '1 : '0;
        if (opsel_q == cur.two_ops) begin
          opsel_d = 1'b0;
          if (ag_tc) begin
            if (elem_q == LAST_ELEM) begin
              state_d = DRAIN;
            end else begin
              elem_d       = elem_q + 3'd1;
              ag_load      = 1'b1;
              ag_load_down = elem_info(elem_q + 3'd1).down;
            end
          end else begin
            ag_step = 1'b1;
          end
        end else begin
          opsel_d = 1'b1;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read compare: expected background registered with the read, checked
  // against rdata in the following cycle (DRAIN covers the last M5 read).
  always_comb begin
    pend_d    = rd_en;
    exp_one_d = (op == R1);
    mismatch  = pend_q && (rdata != (exp_one_q ? {DATA_W{1'b1}} : {DATA_W{1'b0}}));
    fail_d    = launch ? 1'b0 : (fail_q | mismatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      elem_q    <= '0;
      opsel_q   <= 1'b0;
      pend_q    <= 1'b0;
      exp_one_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      opsel_q   <= opsel_d;
      pend_q    <= pend_d;
      exp_one_q <= exp_one_d;
      fail_q    <= fail_d;
    end
  end

  assign fail = fail_q;

`ifdef MBIST_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;

  always_comb begin
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (rd_en) begin
      cmp_addr_d = addr;
      cmp_elem_d = elem_q;
    end
    if (launch) begin
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_mbist_march_sequencer.sv
module tb_mbist_march_sequencer;

  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 8;
  localparam int unsigned N      = 64;
  localparam int unsigned RUN_OPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  logic          fault_en = 1'b0;
  logic [DW-1:0] mem [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          f;
    logic [AW-1:0] fa;
    logic [2:0]    fe;
  } exp_t;

  exp_t exp_q[$];

  mbist_march_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  // Memory model with an optional stuck-at-0 on bit 3 of address 0x15.
  always @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr] & ((fault_en && addr == 6'h15) ? 8'hF7 : 8'hFF);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference op stream of March C- for N=64: {wr, rd, addr[5:0], wdata[7:0]}.
  function automatic logic [15:0] model_op(input int unsigned i);
    int unsigned j;
    logic w, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = 1'b0; r = 1'b0; a = '0; d = '0; j = 0;
    if (i < 64) begin
      w = 1'b1; a = AW'(i);
    end else if (i < 192) begin
      j = i - 64;  a = AW'(j / 2);
      if (j % 2 == 0) r = 1'b1; else begin w = 1'b1; d = 8'hFF; end
    end else if (i < 320) begin
      j = i - 192; a = AW'(j / 2);
      if (j % 2 == 0) r = 1'b1; else w = 1'b1;
    end else if (i < 448) begin
      j = i - 320; a = AW'(63 - j / 2);
      if (j % 2 == 0) r = 1'b1; else begin w = 1'b1; d = 8'hFF; end
    end else if (i < 576) begin
      j = i - 448; a = AW'(63 - j / 2);
      if (j % 2 == 0) r = 1'b1; else w = 1'b1;
    end else begin
      r = 1'b1; a = AW'(i - 576);
    end
    return {w, r, a, d};
  endfunction

  // Monitor: checks every op against the reference stream and, on each
  // done pulse, pops the expected run result from the scoreboard.
  int op_idx = 0;
  int drain_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      op_idx    = 0;
      drain_cnt = 0;
    end else begin
      if (wr_en && rd_en) chk("wr_rd_exclusive", {wr_en, rd_en}, 2'b10);
      if (wr_en || rd_en) begin
        chk("busy_during_op", busy, 1);
        if (op_idx < RUN_OPS) chk("op_stream", {wr_en, rd_en, addr, wdata}, model_op(op_idx));
        else chk("op_overrun", op_idx, RUN_OPS - 1);
        op_idx++;
      end else begin
        chk("wdata_idle", wdata, 0);
        if (busy) drain_cnt++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("run_cycles", op_idx, RUN_OPS);
          chk("drain_cycles", drain_cnt, 1);
          chk("busy_at_done", busy, 0);
          chk("fail", fail, e.f);
          chk("fail_addr", fail_addr, e.fa);
          chk("fail_elem", fail_elem, e.fe);
        end
        op_idx    = 0;
        drain_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    logic found;
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", found, 1);
  endtask

  task automatic push_exp(input logic f, input logic [AW-1:0] fa, input logic [2:0] fe);
    exp_t e;
    e.f = f; e.fa = fa; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic push_faulty();
`ifdef MBIST_FAIL_CAPTURE_EN
    push_exp(1'b1, 6'h15, 3'd2);
`else
    push_exp(1'b1, 6'h00, 3'd0);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_fail_addr"}, fail_addr, 0);
    chk({tag, "_fail_elem"}, fail_elem, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_quiet("reset");

    // Fault-free run, single-cycle start pulse.
    push_exp(1'b0, '0, '0);
    pulse_start();
    wait_done(RUN_OPS + 20);
    tick();
    chk("idle_after_done_busy", busy, 0);

    // Stuck-at-0 bit 3 at 0x15: first mismatch in M2 (r1).
    fault_en = 1'b1;
    push_faulty();
    pulse_start();
    wait_done(RUN_OPS + 20);
    tick();
    chk("fail_sticky_in_idle", fail, 1);

    // Reset at RUN cycle 100 aborts with no done.
    fault_en = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy) begin seen = 1'b1; break; end
      tick();
    end
    chk("run_entered", seen, 1);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("midrun_rst");
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("no_done_after_rst", done, 0);
    end
    push_exp(1'b0, '0, '0);
    pulse_start();
    wait_done(RUN_OPS + 20);
    tick();

    // Start toggled during RUN has no effect.
    push_exp(1'b0, '0, '0);
    start = 1'b1;
    tick();
    seen = 1'b0;
    for (int k = 0; k < RUN_OPS + 20; k++) begin
      start = ((k % 7) < 3);
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    chk("toggle_done_seen", seen, 1);
    tick();

    // Start held high: back-to-back runs with one IDLE cycle between them.
    fault_en = 1'b1;
    push_faulty();
    push_exp(1'b0, '0, '0);
    start = 1'b1;
    tick();
    wait_done(RUN_OPS + 20);
    fault_en = 1'b0;
    tick();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);
    chk("b2b_idle_wr_en", wr_en, 0);
    tick();
    chk("b2b_relaunch_wr_en", wr_en, 1);
    chk("b2b_relaunch_addr", addr, 0);
    chk("b2b_fail_cleared", fail, 0);
    start = 1'b0;
    wait_done(RUN_OPS + 20);
    tick();
    tick();
    chk("final_idle_busy", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
